rx_frame_dispatcher: RTL and testbench

//  Drains the receive-side 16-bit FIFO (clk_rx domain) and sequences it as framed traffic.

---
 rtl/rx_frame_pkg.sv | 24 ++
 rtl/rx_frame_dispatcher.sv | 151 +++++++++++++++
 tb/tb_rx_frame_dispatcher.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_frame_pkg.sv
// Shared definitions for the receive-side frame dispatcher: header layout and FSM encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rx_frame_pkg;

    // Header word layout: [15:12] sync, [11:10] destination, [9:8] reserved, [7:0] length
    localparam logic [3:0] HDR_SYNC = 4'hA;

    localparam int SYNC_MSB = 15;
    localparam int SYNC_LSB = 12;
    localparam int DEST_MSB = 11;
    localparam int DEST_LSB = 10;
    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        HDR_WAIT = 3'd1,
        PAY_REQ  = 3'd2,
        PAY_WAIT = 3'd3,
        PAY_OUT  = 3'd4
    } state_t;

endpackage

// File: rtl/rx_frame_dispatcher.sv
// Drains the rx FIFO as header+payload frames and steers payload words to one of NUM_DEST consumers.
// Latency: header to first m_valid is 3 cycles; at best one payload word every 3 cycles.
// Backpressure: m_ready low holds the current word stable and stops FIFO reads; empty FIFO stalls in PAY_REQ.
module rx_frame_dispatcher
    import rx_frame_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_DEST = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk_rx,
    input  logic                rst_rx,
    input  logic                enable,
    input  logic                fifo_empty,
    input  logic [DATA_W-1:0]   fifo_data,
    output logic                fifo_rd_en,
    output logic [DATA_W-1:0]   m_data,
    output logic [NUM_DEST-1:0] m_valid,
    input  logic [NUM_DEST-1:0] m_ready,
    output logic                m_last,
    output logic                busy,
    output logic                frame_done,
    output logic                hdr_err,
    output logic [CNT_W-1:0]    frame_cnt
);

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  hdr_sync;
    logic [1:0]  hdr_dest;
    logic [7:0]  hdr_len;
    logic        hdr_valid;

    logic [1:0]  dest_q;
    logic [7:0]  remaining;
    logic [3:0]  dest_onehot;
    logic        handshake;

    assign hdr_sync  = fifo_data[SYNC_MSB:SYNC_LSB];
    assign hdr_dest  = fifo_data[DEST_MSB:DEST_LSB];
    assign hdr_len   = fifo_data[LEN_MSB:LEN_LSB];

    // Reserved bits [9:8] are deliberately not part of the acceptance test
    assign hdr_valid = (hdr_sync == HDR_SYNC) && (hdr_len != 8'd0) && (32'(hdr_dest) < NUM_DEST);

    assign dest_onehot = 4'b0001 << dest_q;

    // Only the selected port's valid is ever set, so masking with m_valid ignores other readies
    assign handshake = |(m_valid & m_ready);

    // State register; any illegal encoding is caught by the next-state default
    always_ff @(posedge clk_rx or posedge rst_rx) begin
        if (rst_rx) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode: one FIFO read per word, then wait for the consumer
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_nxt = HDR_WAIT;
                end
            end
            HDR_WAIT: begin
                state_nxt = hdr_valid ? PAY_REQ : IDLE;
            end
            PAY_REQ: begin
                if (!fifo_empty) begin
                    state_nxt = PAY_WAIT;
                end
            end
            PAY_WAIT: begin
                state_nxt = PAY_OUT;
            end
            PAY_OUT: begin
                if (handshake) begin
                    state_nxt = m_last ? IDLE : PAY_REQ;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Read strobe and busy decoded from state; reset forces the strobe low so no word is lost
    always_comb begin
        fifo_rd_en = 1'b0;
        case (state)
            IDLE:    fifo_rd_en = enable && !fifo_empty;
            PAY_REQ: fifo_rd_en = !fifo_empty;
            default: fifo_rd_en = 1'b0;
        endcase
        if (rst_rx) begin
            fifo_rd_en = 1'b0;
        end
        busy = (state != IDLE);
    end

    // Header latch, payload output register, word countdown, status pulses and frame counter
    always_ff @(posedge clk_rx or posedge rst_rx) begin
        if (rst_rx) begin
            dest_q     <= '0;
            remaining  <= '0;
            m_data     <= '0;
            m_valid    <= '0;
            m_last     <= 1'b0;
            frame_done <= 1'b0;
            hdr_err    <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= 1'b0;
            hdr_err    <= 1'b0;
            case (state)
                HDR_WAIT: begin
                    if (hdr_valid) begin
                        dest_q    <= hdr_dest;
                        remaining <= hdr_len;
                    end else begin
                        hdr_err <= 1'b1;
                    end
                end
                PAY_WAIT: begin
                    m_data  <= fifo_data;
                    m_valid <= dest_onehot[NUM_DEST-1:0];
                    m_last  <= (remaining == 8'd1);
                end
                PAY_OUT: begin
                    if (handshake) begin
                        m_valid   <= '0;
                        m_last    <= 1'b0;
                        remaining <= remaining - 8'd1;
                        if (m_last) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_dispatcher.sv
// Directed bench: FIFO model feeds framed traffic, scoreboard holds expected payload beats.
// Monitor samples on the falling edge, pops expectations on every handshake and runs queued checks.
// Stimulus drives 1 time unit after the rising edge.
module tb_rx_frame_dispatcher;

    logic        clk_rx = 1'b0;
    logic        rst_rx = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [15:0] fifo_data = '0;
    logic        fifo_rd_en;
    logic [15:0] m_data;
    logic [3:0]  m_valid;
    logic [3:0]  m_ready = '0;
    logic        m_last;
    logic        busy;
    logic        frame_done;
    logic        hdr_err;
    logic [15:0] frame_cnt;

    always #5 clk_rx = ~clk_rx;

    rx_frame_dispatcher #(.DATA_W(16), .NUM_DEST(4), .CNT_W(16)) dut (
        .clk_rx     (clk_rx),
        .rst_rx     (rst_rx),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .busy       (busy),
        .frame_done (frame_done),
        .hdr_err    (hdr_err),
        .frame_cnt  (frame_cnt)
    );

    typedef struct packed {
        logic [15:0] dat;
        logic [3:0]  vld;
        logic        last;
    } beat_t;

    beat_t        sb_q[$];
    logic [15:0]  fifo_q[$];
    logic [127:0] chk_q[$];
    string        name_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int n_rd     = 0;
    int n_err    = 0;
    int n_done   = 0;
    int n_hs     = 0;
    int n_uflow  = 0;

    // FIFO model: read data appears the cycle after the strobe, empty flag is registered
    always @(posedge clk_rx) begin
        if (fifo_rd_en) begin
            if (fifo_q.size() == 0) begin
                n_uflow <= n_uflow + 1;
            end else begin
                fifo_data <= fifo_q.pop_front();
            end
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({fifo_rd_en, m_data, m_valid, m_last, busy, frame_done, hdr_err, frame_cnt});
    endfunction

    // Monitor: payload scoreboard, hold-stability, pulse timing, then stimulus-queued checks
    initial begin : monitor
        beat_t        exp_b;
        logic [3:0]   prev_vld;
        logic [15:0]  prev_dat;
        logic         prev_last;
        logic         prev_hs;
        logic         pend_done;
        logic         hs;
        logic [15:0]  exp_frames;
        logic [127:0] c;
        prev_vld   = '0;
        prev_dat   = '0;
        prev_last  = 1'b0;
        prev_hs    = 1'b0;
        pend_done  = 1'b0;
        exp_frames = '0;
        forever begin
            @(negedge clk_rx);
            if (rst_rx) begin
                prev_vld   = '0;
                prev_hs    = 1'b0;
                pend_done  = 1'b0;
                exp_frames = '0;
            end else begin
                hs = |(m_valid & m_ready);
                if (fifo_rd_en) begin
                    n_rd++;
                    check("rd_en_while_empty", 64'(fifo_empty), 0);
                end
                if (hdr_err) n_err++;
                check("one_hot_valid", 64'($onehot0(m_valid)), 1);
                check("frame_done_timing", 64'(frame_done), 64'(pend_done));
                if (frame_done) begin
                    n_done++;
                    check("frame_cnt_on_done", 64'(frame_cnt), 64'(exp_frames));
                end
                pend_done = 1'b0;
                if (prev_vld != 4'b0 && !prev_hs) begin
                    check("held_stable", 64'({m_valid, m_data, m_last}), 64'({prev_vld, prev_dat, prev_last}));
                end
                if (hs) begin
                    n_hs++;
                    check("word_expected", 64'(sb_q.size() > 0), 1);
                    if (sb_q.size() > 0) begin
                        exp_b = sb_q.pop_front();
                        check("payload", 64'({m_data, m_valid, m_last}), 64'(exp_b));
                        if (exp_b.last) begin
                            pend_done  = 1'b1;
                            exp_frames = exp_frames + 16'd1;
                        end
                    end
                end
                prev_vld  = m_valid;
                prev_dat  = m_data;
                prev_last = m_last;
                prev_hs   = hs;
            end
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                check(name_q.pop_front(), c[127:64], c[63:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk_rx);
        #1;
    endtask

    task automatic push_chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        name_q.push_back(nm);
        chk_q.push_back({act, exp});
    endtask

    task automatic expect_beat(input logic [15:0] d, input logic [3:0] v, input logic l);
        sb_q.push_back({d, v, l});
    endtask

    task automatic wait_idle(input string nm);
        int t = 0;
        repeat (4) tick();
        while ((busy || sb_q.size() != 0) && t < 400) begin
            tick();
            t++;
        end
        push_chk(nm, 64'(sb_q.size()), 0);
        repeat (2) tick();
    endtask

    task automatic wait_vld(input string nm);
        int t = 0;
        while (m_valid == 4'b0 && t < 100) begin
            tick();
            t++;
        end
        push_chk(nm, 64'(m_valid != 4'b0), 1);
    endtask

    task automatic reset_dut();
        rst_rx = 1'b1;
        repeat (2) tick();
        rst_rx = 1'b0;
        tick();
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int rd;
        int hs0;
        int t;

        // Reset state
        repeat (3) tick();
        push_chk("reset_outputs", outs(), 0);
        rst_rx  = 1'b0;
        tick();
        enable  = 1'b1;
        m_ready = 4'hF;

        // 1: dest 1, three words
        fifo_q.push_back(16'hA403);
        fifo_q.push_back(16'h1111);
        fifo_q.push_back(16'h2222);
        fifo_q.push_back(16'h3333);
        expect_beat(16'h1111, 4'b0010, 1'b0);
        expect_beat(16'h2222, 4'b0010, 1'b0);
        expect_beat(16'h3333, 4'b0010, 1'b1);
        wait_idle("t1_drained");
        push_chk("t1_frame_cnt", 64'(frame_cnt), 1);
        push_chk("t1_done_pulses", 64'(n_done), 1);
        push_chk("t1_hdr_err", 64'(n_err), 0);

        // 2: bad sync word discarded, next word resyncs to a 1-word frame on port 0
        reset_dut();
        fifo_q.push_back(16'h1401);
        fifo_q.push_back(16'hA001);
        fifo_q.push_back(16'hBEEF);
        expect_beat(16'hBEEF, 4'b0001, 1'b1);
        wait_idle("t2_drained");
        push_chk("t2_hdr_err", 64'(n_err), 1);
        push_chk("t2_frame_cnt", 64'(frame_cnt), 1);
        push_chk("t2_done_pulses", 64'(n_done), 2);

        // 3: zero length rejected, nothing forwarded
        hs0 = n_hs;
        fifo_q.push_back(16'hA800);
        wait_idle("t3_drained");
        push_chk("t3_hdr_err", 64'(n_err), 2);
        push_chk("t3_no_valid", 64'(n_hs - hs0), 0);
        push_chk("t3_idle", 64'(busy), 0);
        push_chk("t3_frame_cnt", 64'(frame_cnt), 1);

        // 4: port 3 stalled 10 cycles while other readies are high
        m_ready = 4'b0111;
        fifo_q.push_back(16'hAC02);
        fifo_q.push_back(16'h4444);
        fifo_q.push_back(16'h5555);
        expect_beat(16'h4444, 4'b1000, 1'b0);
        expect_beat(16'h5555, 4'b1000, 1'b1);
        wait_vld("t4_valid_seen");
        rd = 0;
        repeat (10) begin
            tick();
            rd += int'(fifo_rd_en);
        end
        push_chk("t4_stall_rd_en", 64'(rd), 0);
        push_chk("t4_stall_outputs", 64'({m_valid, m_data, m_last}), 64'({4'b1000, 16'h4444, 1'b0}));
        m_ready = 4'hF;
        wait_idle("t4_drained");
        push_chk("t4_frame_cnt", 64'(frame_cnt), 2);
        push_chk("t4_done_pulses", 64'(n_done), 3);

        // 5: LEN=4, FIFO runs dry after two words for 20 cycles
        hs0 = n_hs;
        fifo_q.push_back(16'hA404);
        fifo_q.push_back(16'h7001);
        fifo_q.push_back(16'h7002);
        expect_beat(16'h7001, 4'b0010, 1'b0);
        expect_beat(16'h7002, 4'b0010, 1'b0);
        expect_beat(16'h7003, 4'b0010, 1'b0);
        expect_beat(16'h7004, 4'b0010, 1'b1);
        t = 0;
        while (n_hs - hs0 < 2 && t < 100) begin
            tick();
            t++;
        end
        push_chk("t5_two_words", 64'(n_hs - hs0), 2);
        rd = 0;
        repeat (20) begin
            tick();
            rd += int'(fifo_rd_en);
        end
        push_chk("t5_starve_rd_en", 64'(rd), 0);
        push_chk("t5_starve_busy", 64'(busy), 1);
        push_chk("t5_starve_valid", 64'(m_valid), 0);
        fifo_q.push_back(16'h7003);
        fifo_q.push_back(16'h7004);
        wait_idle("t5_drained");
        push_chk("t5_frame_cnt", 64'(frame_cnt), 3);
        push_chk("t5_done_pulses", 64'(n_done), 4);

        // 6: reset while the second of four words is presented
        m_ready = 4'b0000;
        fifo_q.push_back(16'hA504);
        fifo_q.push_back(16'h6001);
        fifo_q.push_back(16'h6002);
        fifo_q.push_back(16'h6003);
        fifo_q.push_back(16'h6004);
        expect_beat(16'h6001, 4'b0010, 1'b0);
        wait_vld("t6_first_valid");
        m_ready = 4'b0010;
        tick();
        m_ready = 4'b0000;
        wait_vld("t6_second_valid");
        rst_rx = 1'b1;
        #1;
        push_chk("t6_reset_outputs", outs(), 0);
        sb_q.delete();
        repeat (2) tick();
        enable = 1'b0;
        rst_rx = 1'b0;
        rd = 0;
        repeat (10) begin
            tick();
            rd += int'(fifo_rd_en);
        end
        push_chk("t6_disabled_rd_en", 64'(rd), 0);
        push_chk("t6_fifo_untouched", 64'(fifo_q.size()), 2);
        push_chk("t6_frame_cnt", 64'(frame_cnt), 0);
        push_chk("t6_idle", 64'(busy), 0);
        fifo_q.delete();

        push_chk("fifo_underflows", 64'(n_uflow), 0);
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
